// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational 8-bit ALU.
// It owns ACC, CF and a small register file, accepts one instruction per handshake,
// and returns the result on a valid/ready response channel.
module alu_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NREGS  = 4,
    parameter int unsigned REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic              cmd_imm_en,
    input  logic [REG_AW-1:0] cmd_reg,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  alu_opA,
    output logic [WIDTH-1:0]  alu_opB,
    output logic [3:0]        alu_opcode,
    output logic              alu_cin,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_cout,
    output logic [WIDTH-1:0]  acc_out,
    output logic              busy
);

    localparam logic [3:0] OpAdd   = 4'h0;
    localparam logic [3:0] OpSub   = 4'h1;
    localparam logic [3:0] OpLsh   = 4'h2;
    localparam logic [3:0] OpRsh   = 4'h3;
    localparam logic [3:0] OpXor   = 4'h4;
    localparam logic [3:0] OpCmp   = 4'h5;
    localparam logic [3:0] OpAnd   = 4'h6;
    localparam logic [3:0] OpNand  = 4'h7;
    localparam logic [3:0] OpOr    = 4'h8;
    localparam logic [3:0] OpNor   = 4'h9;
    localparam logic [3:0] OpCpy   = 4'hA;
    localparam logic [3:0] OpStore = 4'hB;
    localparam logic [3:0] OpClrc  = 4'hC;
    localparam logic [3:0] OpSetc  = 4'hD;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               cf_q;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opb_q;
    logic [REG_AW-1:0]  reg_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic               rsp_carry_q;
    logic               rsp_err_q;

    // Handshake and status outputs decode directly from the registered state.
    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        busy      = (state_q != StIdle);
        acc_out   = acc_q;
        rsp_data  = rsp_data_q;
        rsp_carry = rsp_carry_q;
        rsp_err   = rsp_err_q;
    end

    // ALU operands are only driven during EXEC; non-ALU commands issue opcode 0.
    always_comb begin
        alu_opA    = '0;
        alu_opB    = '0;
        alu_opcode = '0;
        alu_cin    = 1'b0;
        if (state_q == StExec) begin
            alu_opA    = acc_q;
            alu_opB    = opb_q;
            alu_opcode = (op_q <= OpCpy) ? op_q : 4'h0;
            alu_cin    = cf_q;
        end
    end

    // FSM plus all architectural state; compare flags travel out through rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cf_q        <= 1'b0;
            op_q        <= '0;
            opb_q       <= '0;
            reg_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_opcode;
                        opb_q   <= cmd_imm_en ? cmd_imm : regs_q[cmd_reg];
                        reg_q   <= cmd_reg;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= acc_q;
                    rsp_carry_q <= cf_q;
                    state_q     <= StResp;
                    case (op_q)
                        OpAdd, OpSub, OpLsh, OpRsh: begin
                            acc_q       <= alu_result;
                            cf_q        <= alu_cout;
                            rsp_data_q  <= alu_result;
                            rsp_carry_q <= alu_cout;
                        end
                        OpXor, OpAnd, OpNand, OpOr, OpNor, OpCpy: begin
                            acc_q      <= alu_result;
                            rsp_data_q <= alu_result;
                        end
                        OpCmp:   rsp_data_q <= alu_result;
                        OpStore: regs_q[reg_q] <= acc_q;
                        OpClrc: begin
                            cf_q        <= 1'b0;
                            rsp_carry_q <= 1'b0;
                        end
                        OpSetc: begin
                            cf_q        <= 1'b1;
                            rsp_carry_q <= 1'b1;
                        end
                        default: rsp_err_q <= 1'b1;
                    endcase
                end
                StResp: begin
                    if (rsp_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU model.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_imm_en;
    logic [3:0] cmd_opcode;
    logic [1:0] cmd_reg;
    logic [7:0] cmd_imm;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_err;
    logic [7:0] rsp_data;
    logic [7:0] alu_opA, alu_opB, alu_result, acc_out;
    logic [3:0] alu_opcode;
    logic       alu_cin, alu_cout, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(8), .NREGS(4), .REG_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_imm_en(cmd_imm_en), .cmd_reg(cmd_reg), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .acc_out(acc_out), .busy(busy)
    );

    // Behavioural ALU: logic ops force cout to 0; CMP codes 1 = equal, 2 = A>B, 3 = A<B.
    always_comb begin
        logic [8:0] wide;
        wide       = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            4'h0: begin
                wide = {1'b0, alu_opA} + {1'b0, alu_opB} + {8'd0, alu_cin};
                {alu_cout, alu_result} = wide;
            end
            4'h1: begin
                wide = {1'b0, alu_opA} - {1'b0, alu_opB} + {8'd0, alu_cin};
                {alu_cout, alu_result} = wide;
            end
            4'h2: begin alu_result = {alu_opA[6:0], alu_cin}; alu_cout = alu_opA[7]; end
            4'h3: begin alu_result = {alu_cin, alu_opA[7:1]}; alu_cout = alu_opA[0]; end
            4'h4: alu_result = alu_opA ^ alu_opB;
            4'h5: alu_result = (alu_opA == alu_opB) ? 8'd1 : (alu_opA > alu_opB) ? 8'd2 : 8'd3;
            4'h6: alu_result = alu_opA & alu_opB;
            4'h7: alu_result = ~(alu_opA & alu_opB);
            4'h8: alu_result = alu_opA | alu_opB;
            4'h9: alu_result = ~(alu_opA | alu_opB);
            4'hA: alu_result = alu_opB;
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and step into EXEC, checking the ALU drive there.
    task automatic issue(input logic [3:0] op, input logic en, input logic [1:0] r,
                         input logic [7:0] imm, input logic [7:0] exp_opb);
        cmd_opcode = op;
        cmd_imm_en = en;
        cmd_reg    = r;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_opcode", alu_opcode, (op <= 4'hA) ? op : 4'h0);
        if (op <= 4'hA) check("exec_opB", alu_opB, exp_opb);
    endtask

    // Close EXEC, check the response, then complete the handshake.
    task automatic finish_cmd(input logic [7:0] exp_data, input logic exp_c, input logic exp_err);
        tick();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_carry", rsp_carry, exp_c);
        check("rsp_err", rsp_err, exp_err);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("back_idle", cmd_ready, 1);
    endtask

    task automatic run(input logic [3:0] op, input logic en, input logic [1:0] r,
                       input logic [7:0] imm, input logic [7:0] exp_opb,
                       input logic [7:0] exp_data, input logic exp_c, input logic exp_err);
        issue(op, en, r, imm, exp_opb);
        finish_cmd(exp_data, exp_c, exp_err);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_imm_en = 1'b1;
        cmd_reg = '0; cmd_imm = '0; rsp_ready = 1'b0;
        tick(); tick();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_acc", acc_out, 0);
        check("rst_data", rsp_data, 0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", cmd_ready, 1);

        // Wrap-around add with carry-out into CF.
        issue(4'h0, 1, 0, 8'hFF, 8'hFF);
        check("t1_opA", alu_opA, 8'h00);
        check("t1_cin", alu_cin, 0);
        finish_cmd(8'hFF, 0, 0);
        run(4'h0, 1, 0, 8'h01, 8'h01, 8'h00, 1, 0);
        check("t1_acc", acc_out, 8'h00);

        // Shift pulls CF in; logic ops leave CF alone.
        run(4'hD, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0);
        run(4'hA, 1, 0, 8'h80, 8'h80, 8'h80, 1, 0);
        issue(4'h2, 1, 0, 8'h00, 8'h00);
        check("t2_cin", alu_cin, 1);
        finish_cmd(8'h01, 1, 0);
        run(4'h4, 1, 0, 8'h01, 8'h01, 8'h00, 1, 0);

        // Store, copy, compare against register and immediates.
        run(4'hA, 1, 0, 8'h10, 8'h10, 8'h10, 1, 0);
        run(4'hB, 1, 2, 8'h00, 8'h00, 8'h10, 1, 0);
        run(4'hA, 1, 0, 8'h05, 8'h05, 8'h05, 1, 0);
        run(4'h5, 0, 2, 8'h00, 8'h10, 8'h03, 1, 0);
        check("t3_acc_cmp", acc_out, 8'h05);
        run(4'h5, 1, 0, 8'h05, 8'h05, 8'h01, 1, 0);
        run(4'h5, 1, 0, 8'h04, 8'h04, 8'h02, 1, 0);
        check("t3_acc_keep", acc_out, 8'h05);

        // Subtract with borrow wrap, then logic ops keep CF=1.
        run(4'hC, 1, 0, 8'h00, 8'h00, 8'h05, 0, 0);
        run(4'h1, 1, 0, 8'h03, 8'h03, 8'h02, 0, 0);
        run(4'h1, 1, 0, 8'h05, 8'h05, 8'hFD, 1, 0);
        run(4'h8, 1, 0, 8'h30, 8'h30, 8'hFD, 1, 0);
        run(4'h7, 1, 0, 8'h0F, 8'h0F, 8'hF2, 1, 0);
        run(4'h9, 1, 0, 8'h00, 8'h00, 8'h0D, 1, 0);
        run(4'h6, 1, 0, 8'h07, 8'h07, 8'h05, 1, 0);
        run(4'h0, 1, 0, 8'hED, 8'hED, 8'hF3, 0, 0);

        // Illegal opcode leaves state intact; next op clears rsp_err.
        run(4'hD, 1, 0, 8'h00, 8'h00, 8'hF3, 1, 0);
        run(4'hE, 1, 0, 8'h55, 8'h00, 8'hF3, 1, 1);
        check("t5_acc", acc_out, 8'hF3);
        run(4'hF, 0, 2, 8'h00, 8'h00, 8'hF3, 1, 1);
        run(4'h3, 1, 0, 8'h00, 8'h00, 8'hF9, 1, 0);
        run(4'hA, 0, 2, 8'h00, 8'h10, 8'h10, 1, 0);

        // Backpressure: response held, held command taken only after handshake.
        issue(4'hA, 1, 0, 8'h42, 8'h42);
        tick();
        cmd_opcode = 4'hA; cmd_imm = 8'h77; cmd_imm_en = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", rsp_valid, 1);
            check("t4_hold_data", rsp_data, 8'h42);
            check("t4_hold_ready", cmd_ready, 0);
            tick();
        end
        check("t4_acc", acc_out, 8'h42);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t4_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("t4_exec_busy", busy, 1);
        check("t4_exec_opB", alu_opB, 8'h77);
        finish_cmd(8'h77, 1, 0);

        // Reset in EXEC.
        run(4'hB, 1, 1, 8'h00, 8'h00, 8'h77, 1, 0);
        issue(4'hA, 1, 0, 8'h11, 8'h11);
        #2 rst_n = 1'b0;
        #1;
        check("t6e_busy", busy, 0);
        check("t6e_ready", cmd_ready, 1);
        check("t6e_acc", acc_out, 0);
        check("t6e_opA", alu_opA, 0);
        check("t6e_rsp_valid", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6e_acc_after", acc_out, 0);

        // Reset in RESP with rsp_ready high: response is discarded.
        run(4'hD, 1, 0, 8'h00, 8'h00, 8'h00, 1, 0);
        issue(4'hA, 1, 0, 8'h33, 8'h33);
        tick();
        check("t6r_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6r_valid_rst", rsp_valid, 0);
        check("t6r_data", rsp_data, 0);
        check("t6r_carry", rsp_carry, 0);
        check("t6r_acc", acc_out, 0);
        tick();
        rsp_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        check("t6r_idle_valid", rsp_valid, 0);
        run(4'hA, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
